// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op codes, FSM states and operand sign helpers for the RV32M sequencer
package muldiv_pkg;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } md_op_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        CALC = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } md_state_e;

    function automatic logic signed_a(input md_op_e op);
        return op inside {MULH, MULHSU, DIV, REM};
    endfunction

    function automatic logic signed_b(input md_op_e op);
        return op inside {MULH, DIV, REM};
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add multiply or restoring divide iteration on the 2*XLEN accumulator
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   b,
    input  logic              div,
    output logic [2*XLEN-1:0] nxt
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   upper;
    logic [XLEN-1:0] diff;
    logic            ge;

    // mul: conditional add into the high half then shift right; div: shift left, trial subtract
    always_comb begin
        sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, acc[0] ? b : {XLEN{1'b0}}};
        upper = acc[2*XLEN-1:XLEN-1];
        ge    = upper >= {1'b0, b};
        diff  = upper[XLEN-1:0] - b;
        nxt   = div ? {ge ? diff : upper[XLEN-1:0], acc[XLEN-2:0], ge} : {sum, acc[XLEN-1:1]};
    end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer that stalls the pipeline while it runs
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic            stall,
    output logic [XLEN-1:0] result
);

    md_state_e          state;
    md_op_e             op;
    logic [CNT_W-1:0]   cnt;
    logic [XLEN-1:0]    a;
    logic [XLEN-1:0]    b;
    logic               sa;
    logic               sb;
    logic [2*XLEN-1:0]  acc;
    logic [2*XLEN-1:0]  nxt;

    logic               div;
    logic               na;
    logic               nb;
    logic [XLEN-1:0]    ma;
    logic [XLEN-1:0]    mb;
    logic               special;
    logic [XLEN-1:0]    special_res;
    logic [2*XLEN-1:0]  prod;
    logic [XLEN-1:0]    quo;
    logic [XLEN-1:0]    rem;
    logic [XLEN-1:0]    fix_res;

    assign busy  = state != IDLE;
    assign done  = state == DONE;
    assign stall = (state == IDLE && start && !kill) || state inside {PREP, CALC, FIX};
    assign div   = op[2];

    muldiv_step #(.XLEN(XLEN)) u_step (
        .acc (acc),
        .b   (b),
        .div (div),
        .nxt (nxt)
    );

    // operand magnitudes and early-out results for PREP; sign correction and selection for FIX
    always_comb begin
        na          = signed_a(op) && a[XLEN-1];
        nb          = signed_b(op) && b[XLEN-1];
        ma          = na ? -a : a;
        mb          = nb ? -b : b;
        special     = div && (b == '0 || (!op[0] && a == {1'b1, {(XLEN-1){1'b0}}} && b == '1));
        special_res = b == '0 ? (op[1] ? a : '1) : (op[1] ? '0 : a);
        prod        = (sa ^ sb) ? -acc : acc;
        quo         = (sa ^ sb) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem         = sa ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        fix_res     = div ? (op[1] ? rem : quo) : (op == MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
    end

    // sequencer: accept, prepare, iterate XLEN times, fix signs, present result for one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            op     <= MUL;
            cnt    <= '0;
            a      <= '0;
            b      <= '0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            acc    <= '0;
            result <= '0;
        end else if (kill && state != IDLE) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (start && !kill) begin
                    op    <= md_op_e'(funct3);
                    a     <= op_a;
                    b     <= op_b;
                    state <= PREP;
                end
                PREP: begin
                    sa  <= na;
                    sb  <= nb;
                    a   <= ma;
                    b   <= mb;
                    acc <= {{XLEN{1'b0}}, ma};
                    cnt <= '0;
                    if (special) result <= special_res;
                    state <= special ? DONE : CALC;
                end
                CALC: begin
                    acc <= nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(XLEN - 1)) state <= FIX;
                end
                FIX: begin
                    result <= fix_res;
                    state  <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Iterative sequencer for RV32M multiply/divide. It runs a shift-add multiplier and a restoring divider, one bit per cycle, beside the main ALU. It accepts one operation from execute, stalls the pipeline while it iterates, and returns one registered result.
- ALU Operation encodings are untouched.
- The execute stage routes funct7 = 0000001 R-type instructions here instead of to the ALU.

Parameters:
XLEN, 32, operand/result width; iteration count = XLEN
CNT_W, $clog2(XLEN), width of the iteration counter

Ports:
clk      in   1     clock; all state updates on rising edge
reset    in   1     asynchronous, active-high reset
start    in   1     request an op; sampled only in IDLE
kill     in   1     synchronous abort (pipeline flush); wins over start
funct3   in   3     M-ext op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a     in   XLEN  rs1 value; captured when start is accepted
op_b     in   XLEN  rs2 value; captured when start is accepted
busy     out  1     state != IDLE
done     out  1     one-cycle pulse; result valid this cycle
stall    out  1     (IDLE & start & !kill) | (state not in {IDLE, DONE})
result   out  XLEN  registered result; holds until the next DONE

Behaviour:
- Reset: asynchronous. State = IDLE, counter = 0, all internal registers = 0. busy, done, stall = 0; result = 0. Applies immediately, including mid-operation.
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE: on start & !kill, latch funct3, op_a and op_b, then go to PREP. start in any other state is ignored.
- PREP:
  - Record sign flags. Signed ops: sa = op_a[XLEN-1], sb = op_b[XLEN-1]. MULHSU: sb = 0. Unsigned ops: sa = sb = 0.
  - Replace operands by magnitudes. Load the accumulator and quotient with 0. Counter = 0.
  - Division special cases go straight to DONE:
    - op_b = 0: DIV/DIVU result = all ones; REM/REMU result = op_a.
    - DIV/REM with op_a = 0x80000000 and op_b = 0xFFFFFFFF: DIV result = 0x80000000; REM result = 0.
  - Otherwise go to CALC.
- CALC: one step per cycle for exactly XLEN cycles. Counter counts 0 to XLEN-1; at XLEN-1 go to FIX.
  - Multiply: if the multiplier LSB is 1, add the multiplicand into the upper half of the 2*XLEN product; then shift right.
  - Divide: shift {remainder, dividend} left by 1. Trial subtract the divisor. If non-negative, keep the difference and shift in quotient bit 1; else shift in 0.
- FIX:
  - Multiply: negate the 2*XLEN product if sa ^ sb. MUL selects the low half; MULH, MULHSU and MULHU select the high half.
  - Divide: negate the quotient if sa ^ sb; negate the remainder if sa. DIV/DIVU select the quotient; REM/REMU select the remainder.
  - Load result; go to DONE.
- DONE: done = 1 and stall = 0 for one cycle, so the pipeline advances and captures result. Return to IDLE. A new start can be accepted in the following IDLE cycle.
- Latency, with start accepted in cycle 0:
  - Normal op: PREP in cycle 1, CALC in cycles 2-33, FIX in cycle 34, done in cycle 35.
  - Special case: done in cycle 2.
- kill in any state other than IDLE: next state = IDLE, no done, result unchanged. kill together with start in IDLE means start is not accepted.
- All arithmetic is modulo 2^XLEN (2^(2*XLEN) for the product). Sign handling uses only the latched flags.
- Changing op_a, op_b or funct3 after acceptance has no effect.

Decomposition:
- Package muldiv_pkg holds:
  - enum md_op_e for the funct3 codes
  - enum md_state_e {IDLE, PREP, CALC, FIX, DONE}
  - localparam FUNCT7_MULDIV = 7'b0000001
- One combinational sub-module, muldiv_step, performs one multiply or divide iteration: inputs are accumulator, operands and mode; output is the next accumulator. The FSM and registers stay in muldiv_seq.

Test Plan:
- MUL 7 × 0xFFFFFFFD, start in cycle 0 -> stall 1 in cycles 0-34, done only in cycle 35, result 0xFFFFFFEB, busy 0 in cycle 36.
- MULH 0x80000000 × 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2. Each has done in cycle 35.
- Special cases:
  - DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, done in cycle 2.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0, done in cycle 2.
- Abort and ignored start:
  - start MUL 3×4. Pulse start with different operands in cycle 5 -> ignored.
  - kill in cycle 10 -> IDLE in cycle 11, no done, result keeps its previous value.
  - start DIVU 9/3 in cycle 11 -> result 3 in cycle 46.
- Assert reset asynchronously (between clock edges) in cycle 20 of a DIV -> busy, done, stall and result go to 0 before the next edge. After reset is released, a fresh op completes normally.
